// File: rtl/gc_mem_pkg.sv
// Shared sizing and sweep-FSM state encoding for the gain-cell DRAM refresh ring.
package gc_mem_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 128;

    typedef enum logic [1:0] {
        SR_IDLE,
        SR_SWEEP,
        SR_DRAIN
    } sr_state_t;

endpackage

// File: rtl/gc_mem_array.sv
// Register-file storage: user and refresh write ports, one registered read port.
module gc_mem_array
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_data,
    input  logic              r_we,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    import gc_mem_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];

    // User write beats a refresh copy landing on the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (r_we && !(u_we && (u_addr == r_addr)))
            mem[r_addr] <= r_data;
        if (u_we)
            mem[u_addr] <= u_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/gc_mem_refresh_wrapper.sv
// One bank of the three-bank refresh ring: storage, source sweep FSM and
// destination/redirect handling for the previous bank.
module gc_mem_refresh_wrapper
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] u_data_in,
    input  logic [ADDR_W-1:0] u_write_addr,
    input  logic [ADDR_W-1:0] u_read_addr,
    input  logic              u_we_current,
    input  logic              u_re_current,
    input  logic              u_we_old,
    input  logic              u_re_old,
    input  logic              ref_en_current,
    input  logic              start_SR,
    input  logic              ref_en_old,
    input  logic [DATA_W-1:0] ref_data_in,
    input  logic [ADDR_W-1:0] sr_addr_old,
    input  logic              sr_indicator_old,
    output logic [ADDR_W-1:0] sr_addr_current_out,
    output logic              sr_ref_indicator_current_out,
    output logic              ref_done,
    output logic [DATA_W-1:0] rd
);
    import gc_mem_pkg::*;

    sr_state_t         state;
    logic [ADDR_W-1:0] d_addr;
    logic              d_valid;
    logic              u_we;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                        <= SR_IDLE;
            sr_addr_current_out          <= '0;
            sr_ref_indicator_current_out <= 1'b0;
            ref_done                     <= 1'b0;
        end else begin
            ref_done <= 1'b0;
            if (!ref_en_current) begin
                state                        <= SR_IDLE;
                sr_addr_current_out          <= '0;
                sr_ref_indicator_current_out <= 1'b0;
            end else begin
                case (state)
                    SR_IDLE: begin
                        if (start_SR) begin
                            state                        <= SR_SWEEP;
                            sr_addr_current_out          <= '0;
                            sr_ref_indicator_current_out <= 1'b1;
                        end
                    end
                    SR_SWEEP: begin
                        if (sr_addr_current_out == ADDR_W'(DEPTH - 1)) begin
                            state                        <= SR_DRAIN;
                            sr_ref_indicator_current_out <= 1'b0;
                            ref_done                     <= 1'b1;
                        end else begin
                            sr_addr_current_out <= sr_addr_current_out + 1'b1;
                        end
                    end
                    SR_DRAIN: begin
                        state               <= SR_IDLE;
                        sr_addr_current_out <= '0;
                    end
                    default: begin
                        state                        <= SR_IDLE;
                        sr_addr_current_out          <= '0;
                        sr_ref_indicator_current_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Align the old bank's address with its registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_addr  <= '0;
            d_valid <= 1'b0;
        end else begin
            d_addr  <= sr_addr_old;
            d_valid <= sr_indicator_old & ref_en_old;
        end
    end

    always_comb begin
        u_we    = u_we_current | (u_we_old & ref_en_old);
        rd_en   = sr_ref_indicator_current_out | u_re_current | (u_re_old & ref_en_old);
        rd_addr = sr_ref_indicator_current_out ? sr_addr_current_out : u_read_addr;
    end

    gc_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .u_we    (u_we),
        .u_addr  (u_write_addr),
        .u_data  (u_data_in),
        .r_we    (d_valid),
        .r_addr  (d_addr),
        .r_data  (ref_data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd)
    );

endmodule

// File: tb/tb_gc_mem_refresh_wrapper.sv
// Three-bank refresh ring bench: directed fills, sweeps, redirects and aborts.
module tb_gc_mem_refresh_wrapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] u_data_in = '0;
    logic [6:0]  u_write_addr = '0;
    logic [6:0]  u_read_addr = '0;
    logic [2:0]  we_cur = '0;
    logic [2:0]  re_cur = '0;
    logic [2:0]  we_old = '0;
    logic [2:0]  re_old = '0;
    logic [2:0]  ref_en = '0;
    logic [2:0]  start = '0;

    logic [63:0] rd_w [3];
    logic [6:0]  sr_addr_w [3];
    logic        ind_w [3];
    logic        done_w [3];

    logic [63:0] model [3][128];
    int          wr_cyc [$];
    int          wr_addr [$];
    logic [63:0] wr_dat [$];
    int          rd_cyc = -1;
    int          rd_addr_v = 0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_bank
        gc_mem_refresh_wrapper #(
            .DATA_W (64),
            .ADDR_W (7),
            .DEPTH  (128)
        ) u_bank (
            .clk                          (clk),
            .rst                          (rst),
            .u_data_in                    (u_data_in),
            .u_write_addr                 (u_write_addr),
            .u_read_addr                  (u_read_addr),
            .u_we_current                 (we_cur[g]),
            .u_re_current                 (re_cur[g]),
            .u_we_old                     (we_old[g]),
            .u_re_old                     (re_old[g]),
            .ref_en_current               (ref_en[g]),
            .start_SR                     (start[g]),
            .ref_en_old                   (ref_en[(g+2)%3]),
            .ref_data_in                  (rd_w[(g+2)%3]),
            .sr_addr_old                  (sr_addr_w[(g+2)%3]),
            .sr_indicator_old             (ind_w[(g+2)%3]),
            .sr_addr_current_out          (sr_addr_w[g]),
            .sr_ref_indicator_current_out (ind_w[g]),
            .ref_done                     (done_w[g]),
            .rd                           (rd_w[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int b, input logic [63:0] base, input logic [63:0] step);
        for (int i = 0; i < 128; i++) begin
            u_write_addr = 7'(i);
            u_data_in    = base + step * 64'(i);
            we_cur[b]    = 1'b1;
            model[b][i]  = base + step * 64'(i);
            tick();
            we_cur[b] = 1'b0;
        end
    endtask

    task automatic read_all(input int b);
        for (int i = 0; i < 128; i++) begin
            u_read_addr = 7'(i);
            re_cur[b]   = 1'b1;
            tick();
            re_cur[b] = 1'b0;
            check($sformatf("rd_b%0d_a%0d", b, i), rd_w[b], model[b][i]);
        end
    endtask

    // Source sweep src -> src+1; stop_at drops ref_en, rst_at pulses reset (-1 = never).
    task automatic sweep(input int src, input int stop_at, input int rst_at);
        int dst;
        int done_cnt;
        int done_cyc;
        bit aborted;
        dst      = (src + 1) % 3;
        done_cnt = 0;
        done_cyc = -1;
        aborted  = 1'b0;
        ref_en[src] = 1'b1;
        start[src]  = 1'b1;
        tick();
        start[src] = 1'b0;
        check($sformatf("sr%0d_ind_start", src), 64'(ind_w[src]), 64'd1);
        check($sformatf("sr%0d_addr_start", src), 64'(sr_addr_w[src]), 64'd0);
        for (int k = 1; k <= 131; k++) begin
            if (k == 30) start[src] = 1'b1;
            for (int j = 0; j < wr_cyc.size(); j++) begin
                if (wr_cyc[j] == k) begin
                    u_write_addr = 7'(wr_addr[j]);
                    u_data_in    = wr_dat[j];
                    we_cur[src]  = 1'b1;
                    we_old[dst]  = 1'b1;
                    model[src][wr_addr[j]] = wr_dat[j];
                    model[dst][wr_addr[j]] = wr_dat[j];
                end
            end
            if (k == rd_cyc) begin
                u_read_addr = 7'(rd_addr_v);
                re_old[dst] = 1'b1;
            end
            if (k == stop_at) ref_en[src] = 1'b0;
            if (k == rst_at) rst = 1'b1;
            tick();
            start  = '0;
            we_cur = '0;
            we_old = '0;
            re_old = '0;
            if (k == 1)
                check($sformatf("sr%0d_addr_step", src), 64'(sr_addr_w[src]), 64'd1);
            if (k == rd_cyc && !aborted)
                check($sformatf("redir_rd_b%0d", dst), rd_w[dst], model[src][rd_addr_v]);
            if (k == stop_at || k == rst_at) begin
                aborted = 1'b1;
                check($sformatf("abort%0d_ind", src), 64'(ind_w[src]), 64'd0);
                check($sformatf("abort%0d_addr", src), 64'(sr_addr_w[src]), 64'd0);
                if (k == rst_at) begin
                    check("rst_rd_src", rd_w[src], 64'd0);
                    check("rst_rd_dst", rd_w[dst], 64'd0);
                    check("rst_done", 64'(done_w[src]), 64'd0);
                    rst = 1'b0;
                end
            end
            if (done_w[src]) begin
                done_cnt++;
                done_cyc = k;
            end
        end
        ref_en[src] = 1'b0;
        tick();
        if (aborted) begin
            check($sformatf("sr%0d_no_done", src), 64'(done_cnt), 64'd0);
        end else begin
            check($sformatf("sr%0d_done_cnt", src), 64'(done_cnt), 64'd1);
            check($sformatf("sr%0d_done_cyc", src), 64'(done_cyc), 64'd128);
            for (int i = 0; i < 128; i++) model[dst][i] = model[src][i];
        end
        wr_cyc.delete();
        wr_addr.delete();
        wr_dat.delete();
        rd_cyc = -1;
    endtask

    initial begin
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_rd%0d", g), rd_w[g], 64'd0);
            check($sformatf("rst_addr%0d", g), 64'(sr_addr_w[g]), 64'd0);
            check($sformatf("rst_ind%0d", g), 64'(ind_w[g]), 64'd0);
            check($sformatf("rst_done%0d", g), 64'(done_w[g]), 64'd0);
        end
        rst = 1'b0;
        tick();

        fill(0, 64'd900, 64'd1);
        read_all(0);

        // Late write, early write, and a user/copy collision on addr 40 at edge 42.
        wr_cyc.push_back(42); wr_addr.push_back(40);  wr_dat.push_back(64'd2700);
        wr_cyc.push_back(50); wr_addr.push_back(100); wr_dat.push_back(64'd2600);
        wr_cyc.push_back(51); wr_addr.push_back(10);  wr_dat.push_back(64'd2600);
        sweep(0, -1, -1);
        read_all(1);
        read_all(0);
        check("b1_a100", model[1][100], 64'd2600);

        // Redirected read with the old bank not refreshing must be ignored.
        u_read_addr = 7'd3;
        re_old[1]   = 1'b1;
        tick();
        re_old[1] = 1'b0;
        check("re_old_ignored", rd_w[1], 64'd1027);

        rd_cyc    = 120;
        rd_addr_v = 5;
        sweep(1, -1, -1);
        read_all(2);

        fill(0, 64'd0, 64'd0);
        sweep(2, -1, -1);
        read_all(0);

        sweep(0, 60, -1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("start_no_ref_en", 64'(ind_w[0]), 64'd0);

        sweep(1, -1, 70);
        for (int g = 0; g < 3; g++)
            check($sformatf("end_ind%0d", g), 64'(ind_w[g]), 64'd0);
        read_all(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gc_mem_refresh_wrapper.md
Name: gc_mem_refresh_wrapper

Overview:
- One bank of a three-bank gain-cell DRAM ring (bank0 -> bank1 -> bank2 -> bank0).
- Each wrapper holds a 128x64 storage array and serves user reads and writes.
- A refresh copies every word from the "old" (previous) bank into this "current" bank. While the source bank is busy, this bank takes over user writes and reads addressed to the old bank.
- Instances are chained: `rd`, `sr_addr_current_out` and `sr_ref_indicator_current_out` of one instance feed `ref_data_in`, `sr_addr_old` and `sr_indicator_old` of the next.

Parameters:
- DATA_W, 64, word width.
- ADDR_W, 7, address width.
- DEPTH, 128, words per bank; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- u_data_in  in  DATA_W  user write data.
- u_write_addr  in  ADDR_W  user write address.
- u_read_addr  in  ADDR_W  user read address.
- u_we_current  in  1  user write to this bank.
- u_re_current  in  1  user read from this bank.
- u_we_old  in  1  user write aimed at the old bank.
- u_re_old  in  1  user read aimed at the old bank.
- ref_en_current  in  1  this bank is the refresh source; held high for the whole sweep.
- start_SR  in  1  one-cycle pulse that starts a source sweep; only acted on while ref_en_current=1.
- ref_en_old  in  1  old bank is refreshing; this bank is the destination.
- ref_data_in  in  DATA_W  old bank's `rd`.
- sr_addr_old  in  ADDR_W  old bank's sweep address.
- sr_indicator_old  in  1  old bank's sweep-valid flag.
- sr_addr_current_out  out  ADDR_W  this bank's sweep address (registered).
- sr_ref_indicator_current_out  out  1  this bank's sweep-valid flag (registered).
- ref_done  out  1  one-cycle pulse at end of a sweep.
- rd  out  DATA_W  registered read data; 1-cycle latency.

Behaviour:
- Reset: `rd`=0, `sr_addr_current_out`=0, `sr_ref_indicator_current_out`=0, `ref_done`=0, and all internal delay registers cleared. Array contents are not cleared. Reset mid-sweep aborts the sweep; no done pulse is produced.
- Array: register file with two write ports (user and refresh) and one registered read port.
- Source sweep FSM, states IDLE, SWEEP, DRAIN:
  - IDLE -> SWEEP when start_SR & ref_en_current. At that edge addr=0 and indicator=1.
  - SWEEP: addr increments by 1 each edge. When addr=DEPTH-1, next state is DRAIN and indicator goes to 0. Addr does not wrap during a sweep.
  - DRAIN: one cycle to let the last read reach the destination. `ref_done`=1 for exactly this cycle. Then return to IDLE, addr=0.
  - ref_en_current dropping in any state forces IDLE with indicator=0 and no done pulse.
  - start_SR during SWEEP or DRAIN is ignored.
- Read mux, sampled each edge, in priority order:
  1. While indicator=1: `rd` <= mem[sr_addr_current_out].
  2. Else if u_re_current, or u_re_old & ref_en_old: `rd` <= mem[u_read_addr].
  3. Otherwise `rd` holds its value.
- Reads redirected from the old bank return valid data only for addresses already copied. Guaranteeing this is the controller's responsibility.
- Destination copy:
  - Register sr_addr_old and (sr_indicator_old & ref_en_old) one cycle, giving d_addr and d_valid.
  - When d_valid=1: mem[d_addr] <= ref_data_in.
  - Destination write latency is 2 edges after the source presents an address. A 128-word copy completes within 130 edges of start_SR.
- User write:
  - mem[u_write_addr] <= u_data_in when u_we_current=1, or when u_we_old & ref_en_old.
  - The source bank also writes normally (its own u_we_current). Because both banks take the write, a later copy carries the new value and an earlier copy is not stale.
- Collision: user write and refresh copy to the same address in the same edge: user write wins. Different addresses: both complete.
- u_we_old/u_re_old with ref_en_old=0 are ignored.
- A bank may be refresh source and destination simultaneously; the two paths are independent.

Decomposition:
- Package `gc_mem_pkg`: DATA_W, ADDR_W, DEPTH, sweep-FSM state enum.
- One natural sub-module `gc_mem_array`: 2-write/1-read register file with user-write priority.
- The sweep FSM and redirection logic stay in the wrapper.

Test Plan:
- Reset, then write 900+i to addr i (i=0..127) via u_we_current; read back with u_re_current -> `rd`=900+i one cycle after each address is sampled.
- Fill bank0; pulse start_SR0 with ref_en0 high for 130 edges -> bank1 holds 900+i at every address; `ref_done0` is one single-cycle pulse; bank0 contents unchanged.
- Chain 0->1, 1->2, 2->0 sweeps, clear bank0 between its fill and the final sweep -> reading bank0 returns 900+i for all i.
- During the 0->1 sweep, about 50 edges in, write 2600 to addr 100 with u_we0 -> after the sweep, bank1[100]=2600 and bank0[100]=2600; all other addresses hold 900+i.
- During the same sweep, write 2600 to addr 10 (already copied) -> bank1[10]=2600; also force a user/copy collision on one address -> the user value survives.
- Deassert ref_en_current mid-sweep, and separately assert rst mid-sweep -> indicator drops, no `ref_done`, outputs return to 0 after reset.
